// File: rtl/bram_sequencer.sv
// bram_sequencer: owns the shared BRAM port and steps through LOAD -> SOLVE -> DONE.
// The parser may write only in LOAD and the solver may read or write only in SOLVE.
// Requests are registered onto the port. Reads return a valid strobe matched to the latency.
module bram_sequencer #(
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned DATA_WIDTH   = 13,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    // parser (write-only loader)
    input  logic                  p_valid,
    input  logic [ADDR_WIDTH-1:0] p_addr,
    input  logic [DATA_WIDTH-1:0] p_data,
    output logic                  p_ready,
    input  logic                  board_done,
    // solver
    input  logic                  s_valid,
    input  logic                  s_we,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  s_rvalid,
    input  logic                  solve_done,
    // BRAM port
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_we,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    // status
    output logic [1:0]            phase,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  err
);

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StSolve = 2'd1,
        StDone  = 2'd2
    } state_e;

    // One extra stage past the BRAM latency covers the registered address cycle.
    localparam int unsigned VDepth = READ_LATENCY + 1;

    state_e                state_q, state_d;
    logic                  closing_q, closing_d;
    logic                  err_q, err_d;
    logic [VDepth-1:0]     rvld_q, rvld_d;
    logic [ADDR_WIDTH:0]   wr_count_q, wr_count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  we_q, we_d;
    logic                  p_accept, s_accept, s_rd_accept;

    // Handshakes depend on phase, closing and solve_done only. They never depend on the valids.
    always_comb begin
        p_ready     = (state_q == StLoad);
        s_ready     = (state_q == StSolve) && !closing_q && !solve_done;
        p_accept    = p_valid && p_ready;
        s_accept    = s_valid && s_ready;
        s_rd_accept = s_accept && !s_we;
    end

    // Next-state for the phase FSM, port registers, read-valid pipe and error flag.
    always_comb begin
        state_d    = state_q;
        closing_d  = closing_q;
        err_d      = err_q;
        addr_d     = addr_q;
        din_d      = din_q;
        we_d       = 1'b0;
        wr_count_d = wr_count_q;
        rvld_d     = (rvld_q << 1) | VDepth'(s_rd_accept);

        if (p_accept) begin
            addr_d = p_addr;
            din_d  = p_data;
            we_d   = 1'b1;
            if (wr_count_q != '1) begin
                wr_count_d = wr_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
        end else if (s_accept) begin
            addr_d = s_addr;
            din_d  = s_wdata;
            we_d   = s_we;
        end

        if ((p_valid && state_q != StLoad) || (s_valid && state_q == StLoad) ||
            (board_done && state_q != StLoad) || (solve_done && state_q != StSolve)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StLoad: begin
                if (board_done) state_d = StSolve;
            end
            StSolve: begin
                if (solve_done) closing_d = 1'b1;
                // Look at the shifted pipe so DONE follows the last s_rvalid immediately.
                if (closing_d && rvld_d == '0) state_d = StDone;
            end
            StDone:  state_d = StDone;
            default: state_d = StLoad;
        endcase
    end

    // State registers with synchronous reset. A reset drops any reads still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLoad;
            closing_q  <= 1'b0;
            err_q      <= 1'b0;
            rvld_q     <= '0;
            wr_count_q <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            closing_q  <= closing_d;
            err_q      <= err_d;
            rvld_q     <= rvld_d;
            wr_count_q <= wr_count_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            we_q       <= we_d;
        end
    end

    assign bram_addr = addr_q;
    assign bram_din  = din_q;
    assign bram_we   = we_q;
    assign s_rdata   = bram_dout;
    assign s_rvalid  = rvld_q[VDepth-1];
    assign phase     = state_q;
    assign wr_count  = wr_count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bram_sequencer.sv
// Bench for bram_sequencer. Directed stimulus, a behavioural model checked every cycle,
// and a read-first BRAM model with a latency of 2.
module tb_bram_sequencer;

    localparam int AW    = 4;
    localparam int DW    = 13;
    localparam int RL    = 2;
    localparam int WcMax = (1 << (AW + 1)) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          p_valid, p_ready, board_done;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    logic          s_valid, s_we, s_ready, s_rvalid, solve_done;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din, bram_dout;
    logic          bram_we;
    logic [1:0]    phase;
    logic [AW:0]   wr_count;
    logic          err;

    int tests = 0;
    int fails = 0;

    bram_sequencer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .READ_LATENCY(RL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p_valid   (p_valid),
        .p_addr    (p_addr),
        .p_data    (p_data),
        .p_ready   (p_ready),
        .board_done(board_done),
        .s_valid   (s_valid),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .s_rvalid  (s_rvalid),
        .solve_done(solve_done),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_we   (bram_we),
        .bram_dout (bram_dout),
        .phase     (phase),
        .wr_count  (wr_count),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Read-first single-port BRAM with two output register stages.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe;
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        rd_pipe   <= mem[bram_addr];
        bram_dout <= rd_pipe;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            cyc = 0;
    bit            model_ok = 1'b0;
    int            m_phase, m_wc;
    bit            m_closing, m_err, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    int            due_q[$];
    logic [DW-1:0] dat_q[$];

    task automatic model_step();
        bit prdy, srdy;
        if (rst) begin
            model_ok  = 1'b1;
            m_phase   = 0;
            m_closing = 1'b0;
            m_err     = 1'b0;
            m_wc      = 0;
            m_we      = 1'b0;
            m_addr    = '0;
            m_din     = '0;
            due_q.delete();
            dat_q.delete();
        end else if (model_ok) begin
            prdy = (m_phase == 0);
            srdy = (m_phase == 1) && !m_closing && !solve_done;
            if ((p_valid && m_phase != 0) || (s_valid && m_phase == 0) ||
                (board_done && m_phase != 0) || (solve_done && m_phase != 1)) m_err = 1'b1;
            m_we = 1'b0;
            if (p_valid && prdy) begin
                m_we           = 1'b1;
                m_addr         = p_addr;
                m_din          = p_data;
                m_mem[p_addr]  = p_data;
                if (m_wc < WcMax) m_wc++;
            end else if (s_valid && srdy) begin
                m_we   = s_we;
                m_addr = s_addr;
                m_din  = s_wdata;
                if (s_we) m_mem[s_addr] = s_wdata;
                else begin
                    due_q.push_back(cyc + 1 + RL);
                    dat_q.push_back(m_mem[s_addr]);
                end
            end
            if (m_phase == 0 && board_done) m_phase = 1;
            else if (m_phase == 1) begin
                if (solve_done) m_closing = 1'b1;
                if (m_closing && due_q.size() == 0) m_phase = 2;
            end
        end
        cyc++;
    endtask

    task automatic compare();
        bit exp_rv;
        exp_rv = (due_q.size() > 0) && (due_q[0] == cyc);
        check("phase", 32'(phase), 32'(m_phase));
        check("p_ready", 32'(p_ready), 32'(m_phase == 0));
        check("s_ready", 32'(s_ready), 32'((m_phase == 1) && !m_closing && !solve_done));
        check("bram_we", 32'(bram_we), 32'(m_we));
        check("bram_addr", 32'(bram_addr), 32'(m_addr));
        check("bram_din", 32'(bram_din), 32'(m_din));
        check("wr_count", 32'(wr_count), 32'(m_wc));
        check("err", 32'(err), 32'(m_err));
        check("s_rvalid", 32'(s_rvalid), 32'(exp_rv));
        if (exp_rv) begin
            check("s_rdata", 32'(s_rdata), 32'(dat_q[0]));
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) compare();
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; p_valid = 1'b0; p_addr = '0; p_data = '0; board_done = 1'b0;
        s_valid = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0; solve_done = 1'b0;

        // Reset values
        do_reset();
        check("rst_phase", 32'(phase), 0);
        check("rst_p_ready", 32'(p_ready), 1);
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_bram_we", 32'(bram_we), 0);
        check("rst_bram_addr", 32'(bram_addr), 0);
        check("rst_bram_din", 32'(bram_din), 0);
        check("rst_s_rvalid", 32'(s_rvalid), 0);
        check("rst_wr_count", 32'(wr_count), 0);
        check("rst_err", 32'(err), 0);

        // Load five words. board_done comes with the fifth write.
        for (int i = 0; i < 5; i++) begin
            p_valid = 1'b1; p_addr = AW'(i); p_data = DW'(13'h1000 + i); board_done = (i == 4);
            step();
        end
        p_valid = 1'b0; board_done = 1'b0;
        check("load_phase", 32'(phase), 1);
        check("load_wr_count", 32'(wr_count), 5);
        check("load_last_we", 32'(bram_we), 1);
        check("load_last_addr", 32'(bram_addr), 4);
        check("load_last_din", 32'(bram_din), 32'h1004);

        // Back-to-back reads of 0..4. The valid strobe arrives three cycles after each accept.
        for (int k = 0; k < 10; k++) begin
            check("pipe_rvalid", 32'(s_rvalid), 32'(k >= 3 && k <= 7));
            if (k >= 3 && k <= 7) check("pipe_rdata", 32'(s_rdata), 32'h1000 + k - 3);
            s_valid = (k < 5); s_we = 1'b0; s_addr = AW'(k);
            step();
        end
        s_valid = 1'b0;

        // A solver write, then a read of the same address on the next cycle.
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                check("wr_rd_rvalid", 32'(s_rvalid), 1);
                check("wr_rd_rdata", 32'(s_rdata), 32'h0abc);
            end
            s_valid = (k < 2); s_we = (k == 0); s_addr = AW'(5); s_wdata = 13'h0abc;
            step();
        end
        s_valid = 1'b0; s_we = 1'b0;

        // Drain: two reads, then solve_done while s_valid stays high.
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                check("drain_rv0", 32'(s_rvalid), 1);
                check("drain_rd0", 32'(s_rdata), 32'h1001);
            end
            if (k == 4) begin
                check("drain_rv1", 32'(s_rvalid), 1);
                check("drain_rd1", 32'(s_rdata), 32'h1002);
                check("drain_phase_pre", 32'(phase), 1);
            end
            if (k >= 5) begin
                check("drain_rv_none", 32'(s_rvalid), 0);
                check("drain_phase_done", 32'(phase), 2);
            end
            s_valid = 1'b1; s_we = (k >= 2);
            s_addr = (k == 0) ? AW'(1) : (k == 1) ? AW'(2) : AW'(3);
            solve_done = (k == 2);
            #1;
            if (k == 1) check("drain_ready_before", 32'(s_ready), 1);
            if (k == 2) check("drain_ready_drop", 32'(s_ready), 0);
            step();
        end
        s_valid = 1'b0; s_we = 1'b0; solve_done = 1'b0;
        check("drain_no_err", 32'(err), 0);

        // Protocol error: a parser write while in SOLVE.
        do_reset();
        p_valid = 1'b1; p_addr = '0; p_data = 13'h0111; board_done = 1'b1;
        step();
        board_done = 1'b0; p_addr = AW'(7); p_data = 13'h1fff;
        step();
        p_valid = 1'b0;
        check("perr_err", 32'(err), 1);
        check("perr_phase", 32'(phase), 1);
        check("perr_we", 32'(bram_we), 0);
        step(); step();
        check("perr_sticky", 32'(err), 1);
        check("perr_phase_hold", 32'(phase), 1);

        // Protocol error: a solver request while in LOAD.
        do_reset();
        s_valid = 1'b1; s_we = 1'b1; s_addr = AW'(2); s_wdata = 13'h0222;
        step();
        s_valid = 1'b0; s_we = 1'b0;
        check("serr_err", 32'(err), 1);
        check("serr_phase", 32'(phase), 0);
        check("serr_we", 32'(bram_we), 0);
        check("serr_wr_count", 32'(wr_count), 0);
        step();
        check("serr_sticky", 32'(err), 1);

        // Reset one cycle after a read is accepted drops that read.
        do_reset();
        p_valid = 1'b1; p_addr = '0; p_data = 13'h0555; board_done = 1'b1;
        step();
        p_valid = 1'b0; board_done = 1'b0;
        s_valid = 1'b1; s_we = 1'b0; s_addr = '0;
        step();
        s_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("mrst_rvalid", 32'(s_rvalid), 0);
            check("mrst_phase", 32'(phase), 0);
            check("mrst_wr_count", 32'(wr_count), 0);
            step();
        end

        // wr_count saturates at all-ones. With ADDR_WIDTH = 4 that is 31.
        for (int i = 0; i < WcMax + 2; i++) begin
            p_valid = 1'b1; p_addr = AW'(i); p_data = DW'(i);
            step();
        end
        p_valid = 1'b0;
        check("sat_wr_count", 32'(wr_count), 31);
        board_done = 1'b1;
        step();
        board_done = 1'b0;
        check("sat_phase_solve", 32'(phase), 1);
        solve_done = 1'b1;
        step();
        solve_done = 1'b0;
        check("idle_done_phase", 32'(phase), 2);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
